// File: rtl/fifo_tx_buffer_if.sv
// Bridge-side and FT245-side handshake signals of the transmit buffer.
// The master modport is the environment (bridge + FT245); slave is the buffer.
interface fifo_tx_buffer_if;
  logic       up_wr;
  logic [6:0] up_data;
  logic       up_rd;
  logic       up_txe;
  logic       fifo_txe;
  logic       fifo_wr;
  logic [6:0] fifo_data_out;
  logic       fifo_data_oe;

  modport master (
    output up_wr, up_data, up_rd, fifo_txe,
    input  up_txe, fifo_wr, fifo_data_out, fifo_data_oe
  );

  modport slave (
    input  up_wr, up_data, up_rd, fifo_txe,
    output up_txe, fifo_wr, fifo_data_out, fifo_data_oe
  );
endinterface

// File: rtl/fifo_tx_buffer.sv
// Elastic transmit buffer between the PIA bridge and the FT245 USB FIFO,
// with optional CR -> CR LF expansion on the drain side.
module fifo_tx_buffer #(
  parameter int DEPTH_LOG2    = 4,
  parameter int STROBE_CYCLES = 2,
  parameter int CRLF          = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  fifo_tx_buffer_if.slave       bus,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE     = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = (DEPTH_LOG2)'(1);
  localparam logic [3:0]            STROBE_LAST = 4'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t                state;
  logic [6:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [3:0]            strobe_cnt;
  logic                  up_wr_q;
  logic                  empty_q;
  logic                  lf_pend;
  logic                  full;
  logic                  push;
  logic                  push_ok;
  logic                  pop;
  logic                  start;

  assign full    = (count == FULL_COUNT);
  assign push    = !bus.up_wr && up_wr_q;
  assign push_ok = push && !full;
  assign pop     = (state == HOLD) && !lf_pend;
  assign level   = count;

  // A freshly pushed entry only becomes eligible for draining once empty_q
  // has caught up, giving the two-clock push-to-SETUP latency from empty.
  assign start = ((count != '0 && !empty_q) || lf_pend) && !bus.fifo_txe && bus.up_rd;

  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      mem[wr_ptr] <= bus.up_data;
    end
  end

  // Pointer, occupancy and flag bookkeeping; fullness is judged before any pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      up_wr_q    <= 1'b1;
      empty_q    <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      bus.up_txe <= 1'b0;
    end else begin
      up_wr_q    <= bus.up_wr;
      empty_q    <= (count == '0);
      bus.up_txe <= full;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (push && full) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Drain sequencer; the byte on the bus is latched at SETUP and held
  // through HOLD so it brackets the write strobe on both sides.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= IDLE;
      bus.fifo_wr       <= 1'b1;
      bus.fifo_data_oe  <= 1'b0;
      bus.fifo_data_out <= '0;
      strobe_cnt        <= '0;
      lf_pend           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state             <= SETUP;
            bus.fifo_data_oe  <= 1'b1;
            bus.fifo_data_out <= lf_pend ? 7'h0A : mem[rd_ptr];
          end
        end
        SETUP: begin
          state       <= STROBE;
          bus.fifo_wr <= 1'b0;
          strobe_cnt  <= STROBE_LAST;
        end
        STROBE: begin
          if (strobe_cnt == '0) begin
            state       <= HOLD;
            bus.fifo_wr <= 1'b1;
          end else begin
            strobe_cnt <= strobe_cnt - 4'd1;
          end
        end
        HOLD: begin
          state            <= IDLE;
          bus.fifo_data_oe <= 1'b0;
          if (lf_pend) begin
            lf_pend <= 1'b0;
          end else if (CRLF != 0 && mem[rd_ptr] == 7'h0D) begin
            lf_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_tx_buffer.sv
// Scoreboard bench for fifo_tx_buffer: two instances (CRLF on and off) share
// one stimulus stream; a negedge monitor checks every FT245 write against a queue.
module tb_fifo_tx_buffer;

  localparam int STROBE = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       overflow0;
  logic       overflow1;
  logic [4:0] level0;
  logic [4:0] level1;

  fifo_tx_buffer_if bus0 ();
  fifo_tx_buffer_if bus1 ();

  assign bus1.up_wr    = bus0.up_wr;
  assign bus1.up_data  = bus0.up_data;
  assign bus1.up_rd    = bus0.up_rd;
  assign bus1.fifo_txe = bus0.fifo_txe;

  fifo_tx_buffer #(.DEPTH_LOG2(4), .STROBE_CYCLES(STROBE), .CRLF(1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .overflow(overflow0), .level(level0)
  );

  fifo_tx_buffer #(.DEPTH_LOG2(4), .STROBE_CYCLES(STROBE), .CRLF(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .overflow(overflow1), .level(level1)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [6:0] q0[$];
  logic [6:0] q1[$];
  logic       prev_wr[2]  = '{1'b1, 1'b1};
  logic       prev_oe[2]  = '{1'b0, 1'b0};
  logic [6:0] prev_data[2];
  logic       in_pulse[2] = '{1'b0, 1'b0};
  int         low_len[2]  = '{0, 0};
  logic [6:0] sent[2];
  int         pulses[2]   = '{0, 0};

  task automatic check_output(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: the CRLF=1 unit emits an extra LF after every CR, the other does not.
  function automatic void add_expected(input logic [6:0] c);
    q0.push_back(c);
    if (c == 7'h0D) q0.push_back(7'h0A);
    q1.push_back(c);
  endfunction

  task automatic monitor_step(input int k, input logic rst, input logic wr,
                              input logic oe, input logic [6:0] data);
    logic [6:0] exp_byte;
    int         qs;
    if (!rst) begin
      in_pulse[k] = 1'b0;
      prev_wr[k]  = 1'b1;
      prev_oe[k]  = 1'b0;
      return;
    end
    if (prev_wr[k] && !wr) begin
      qs = (k == 0) ? q0.size() : q1.size();
      if (qs > 0) begin
        exp_byte = (k == 0) ? q0.pop_front() : q1.pop_front();
        check_output($sformatf("byte_order%0d", k), data, exp_byte);
        check_output($sformatf("setup_data%0d", k), prev_data[k], exp_byte);
        check_output($sformatf("setup_oe%0d", k), prev_oe[k], 1);
      end else begin
        exp_byte = data;
        check_output($sformatf("spurious_write%0d_queue", k), qs, 1);
      end
      in_pulse[k] = 1'b1;
      low_len[k]  = 1;
      sent[k]     = exp_byte;
    end else if (in_pulse[k] && !wr) begin
      low_len[k]++;
    end else if (in_pulse[k] && wr) begin
      check_output($sformatf("strobe_len%0d", k), low_len[k], STROBE);
      check_output($sformatf("hold_oe%0d", k), oe, 1);
      check_output($sformatf("hold_data%0d", k), data, sent[k]);
      in_pulse[k] = 1'b0;
      pulses[k]++;
    end
    prev_wr[k]   = wr;
    prev_oe[k]   = oe;
    prev_data[k] = data;
  endtask

  always @(negedge clk) begin
    monitor_step(0, reset, bus0.fifo_wr, bus0.fifo_data_oe, bus0.fifo_data_out);
    monitor_step(1, reset, bus1.fifo_wr, bus1.fifo_data_oe, bus1.fifo_data_out);
  end

  task automatic apply_stimulus(input logic [6:0] c, input int hold, input bit expect_accept);
    @(negedge clk);
    bus0.up_data = c;
    bus0.up_wr   = 1'b0;
    if (expect_accept) add_expected(c);
    repeat (hold) @(negedge clk);
    bus0.up_wr = 1'b1;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && level0 == 0 && level1 == 0 &&
          !in_pulse[0] && !in_pulse[1]) done = 1'b1;
    end
    check_output("drain_complete", done, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [6:0] c;
    int         base;
    int         pushed;
    int         hold;
    bit         seen;

    reset         = 1'b0;
    bus0.up_wr    = 1'b1;
    bus0.up_data  = '0;
    bus0.up_rd    = 1'b1;
    bus0.fifo_txe = 1'b1;

    repeat (3) @(negedge clk);
    check_output("rst_wr0", bus0.fifo_wr, 1);
    check_output("rst_oe0", bus0.fifo_data_oe, 0);
    check_output("rst_txe0", bus0.up_txe, 0);
    check_output("rst_level0", level0, 0);
    check_output("rst_ovf0", overflow0, 0);
    check_output("rst_wr1", bus1.fifo_wr, 1);
    check_output("rst_level1", level1, 0);
    reset = 1'b1;

    // Single character: exact strobe timing relative to the push edge.
    @(negedge clk);
    bus0.fifo_txe = 1'b0;
    @(negedge clk);
    bus0.up_data = 7'h41;
    bus0.up_wr   = 1'b0;
    add_expected(7'h41);
    @(posedge clk);
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus0.up_wr = 1'b1;
        check_output("single_level_up", level0, 1);
      end
      check_output($sformatf("single_wr_t%0d", i), bus0.fifo_wr, (i == 3 || i == 4) ? 0 : 1);
      check_output($sformatf("single_oe_t%0d", i), bus0.fifo_data_oe, (i >= 2 && i <= 5) ? 1 : 0);
      if (i == 6) begin
        check_output("single_level_down", level0, 0);
        check_output("single_wr_inst1", bus1.fifo_wr, 1);
      end
    end
    wait_drain();

    // CR expansion on one instance, pass-through on the other.
    apply_stimulus(7'h0D, 1, 1'b1);
    apply_stimulus(7'h42, 2, 1'b1);
    wait_drain();

    // Fill to capacity with the FT245 busy, then overflow.
    bus0.fifo_txe = 1'b1;
    for (int i = 0; i < 16; i++) apply_stimulus(7'(7'h50 + i), 1, 1'b1);
    repeat (2) @(negedge clk);
    check_output("full_level0", level0, 16);
    check_output("full_level1", level1, 16);
    check_output("full_up_txe", bus0.up_txe, 1);
    check_output("full_no_ovf", overflow0, 0);
    apply_stimulus(7'h7E, 3, 1'b0);
    repeat (2) @(negedge clk);
    check_output("ovf_flag0", overflow0, 1);
    check_output("ovf_flag1", overflow1, 1);
    check_output("ovf_level", level0, 16);
    base = pulses[0];
    bus0.fifo_txe = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (pulses[0] != base) seen = 1'b1;
    end
    check_output("first_pop_seen", seen, 1);
    repeat (2) @(negedge clk);
    check_output("up_txe_release", bus0.up_txe, 0);
    check_output("ovf_sticky", overflow0, 1);
    wait_drain();

    // Bridge holds the bus: nothing may be written until up_rd returns high.
    @(negedge clk);
    bus0.up_rd = 1'b0;
    base = pulses[0];
    apply_stimulus(7'h61, 1, 1'b1);
    apply_stimulus(7'h62, 1, 1'b1);
    apply_stimulus(7'h63, 1, 1'b1);
    repeat (20) @(negedge clk);
    check_output("rd_block_pulses", pulses[0] - base, 0);
    check_output("rd_block_level", level0, 3);
    bus0.up_rd = 1'b1;
    @(posedge clk);
    #1;
    check_output("rd_release_oe", bus0.fifo_data_oe, 1);
    wait_drain();

    // Randomized traffic with busy/bus-held gaps; 40 pushes wrap the pointers.
    pushed = 0;
    hold   = 0;
    for (int cyc = 0; cyc < 6000 && (pushed < 40 || bus0.up_wr == 1'b0); cyc++) begin
      @(negedge clk);
      bus0.fifo_txe = ($urandom_range(0, 3) == 0);
      bus0.up_rd    = ($urandom_range(0, 6) != 0);
      if (bus0.up_wr == 1'b0) begin
        hold--;
        if (hold == 0) bus0.up_wr = 1'b1;
      end else if (pushed < 40 && q0.size() <= 12 && $urandom_range(0, 1) == 1) begin
        c = ($urandom_range(0, 4) == 0) ? 7'h0D : 7'($urandom_range(0, 127));
        bus0.up_data = c;
        bus0.up_wr   = 1'b0;
        hold         = $urandom_range(1, 3);
        add_expected(c);
        pushed++;
      end
    end
    bus0.up_wr    = 1'b1;
    bus0.fifo_txe = 1'b0;
    bus0.up_rd    = 1'b1;
    check_output("random_pushes", pushed, 40);
    wait_drain();

    // Reset asserted in the middle of a write strobe.
    apply_stimulus(7'h55, 1, 1'b1);
    apply_stimulus(7'h56, 1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus0.fifo_wr == 1'b0) seen = 1'b1;
    end
    check_output("mid_strobe_seen", seen, 1);
    reset = 1'b0;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    check_output("midrst_wr", bus0.fifo_wr, 1);
    check_output("midrst_oe", bus0.fifo_data_oe, 0);
    check_output("midrst_level", level0, 0);
    check_output("midrst_ovf", overflow0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    base = pulses[0];
    repeat (30) @(negedge clk);
    check_output("post_rst_pulses", pulses[0] - base, 0);
    check_output("post_rst_level", level0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
